// File: rtl/switch_gate_debounced_if.sv
// Switch-pin / LED-pin bundle for switch_gate_debounced, plus the exported
// debounced state, press/release events and current gate mode.
interface switch_gate_debounced_if #(
  parameter int NUM_SW = 5
);
  logic [NUM_SW-1:0] nSwitch;
  logic [5:0]        nLed;
  logic [NUM_SW-1:0] sw_state;
  logic [NUM_SW-1:0] sw_press;
  logic [NUM_SW-1:0] sw_release;
  logic [2:0]        mode;

  modport master (
    output nSwitch,
    input  nLed, sw_state, sw_press, sw_release, mode
  );

  modport slave (
    input  nSwitch,
    output nLed, sw_state, sw_press, sw_release, mode
  );
endinterface

// File: rtl/switch_gate_debounced.sv
// Synchronise and debounce active-low switches, emit press/release pulses, cycle a 2-input gate
// with switch 0 and show operands/result/mode on active-low LEDs; edge-to-state latency is fixed, no backpressure.
module switch_gate_debounced #(
  parameter int NUM_SW          = 5,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  switch_gate_debounced_if.slave   sw_if
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][NUM_SW-1:0] sync_q, sync_d;
  logic [NUM_SW-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SW-1:0]                  state_q, state_d;
  logic [NUM_SW-1:0]                  press_q, press_d;
  logic [NUM_SW-1:0]                  release_q, release_d;
  logic [2:0]                         mode_q, mode_d;
  logic [NUM_SW-1:0]                  sync_out;
  logic                               gate_f;

  always_comb begin
    sync_d[0] = ~sw_if.nSwitch;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Any sample matching the stable level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sync_out[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        state_d[i]   = sync_out[i];
        press_d[i]   = sync_out[i];
        release_d[i] = ~sync_out[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (press_q[0]) begin
      mode_d = (mode_q >= 3'd5) ? 3'd0 : mode_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      mode_q    <= 3'd0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      mode_q    <= mode_d;
    end
  end

  always_comb begin
    gate_f = 1'b0;
    case (mode_q)
      3'd0:    gate_f =   state_q[1] & state_q[2];
      3'd1:    gate_f =   state_q[1] | state_q[2];
      3'd2:    gate_f =   state_q[1] ^ state_q[2];
      3'd3:    gate_f = ~(state_q[1] & state_q[2]);
      3'd4:    gate_f = ~(state_q[1] | state_q[2]);
      3'd5:    gate_f = ~(state_q[1] ^ state_q[2]);
      default: gate_f =   state_q[1] & state_q[2];
    endcase
  end

  assign sw_if.nLed       = ~{mode_q, gate_f, state_q[2], state_q[1]};
  assign sw_if.sw_state   = state_q;
  assign sw_if.sw_press   = press_q;
  assign sw_if.sw_release = release_q;
  assign sw_if.mode       = mode_q;

endmodule
